// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation processing elements.
package me_pkg;

    // Default pixel width used by the 4K60 motion-estimation core.
    localparam int PIX_W_DEF = 8;

    // Pixel and SAD types for the default configuration (16-pixel block).
    typedef logic [PIX_W_DEF-1:0]   pix_t;
    typedef logic [PIX_W_DEF+4-1:0] sad_t;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_ad_lane.sv
// One absolute-difference lane: stage-1 current/previous pixel registers
// (the current one can be held for reuse across beats) and |crt - pre|.
module pe_ad_lane
    import me_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_i,
    input  logic             keep_i,
    input  logic [PIX_W-1:0] crt_i,
    input  logic [PIX_W-1:0] pre_i,
    output logic [PIX_W-1:0] crt_o,
    output logic [PIX_W-1:0] pre_o,
    output logic [PIX_W-1:0] ad_o
);

    logic [PIX_W-1:0] crt_q;
    logic [PIX_W-1:0] pre_q;

    // Stage-1 pixel registers; a bubble (ld_i=0) holds both.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crt_q <= '0;
            pre_q <= '0;
        end else if (ld_i) begin
            pre_q <= pre_i;
            if (!keep_i) begin
                crt_q <= crt_i;
            end
        end
    end

    // Unsigned absolute difference: subtract the smaller from the larger.
    assign ad_o  = (crt_q >= pre_q) ? (crt_q - pre_q) : (pre_q - crt_q);
    assign crt_o = crt_q;
    assign pre_o = pre_q;

endmodule

// File: rtl/pe_sad_acc.sv
// Multi-lane SAD processing element: per-lane |crt-pre|, lane sum, block
// accumulation and minimum-SAD tracking across the candidates of a window.
module pe_sad_acc
    import me_pkg::*;
#(
    parameter  int PIX_W      = PIX_W_DEF,
    parameter  int LANES      = 4,
    parameter  int BLK_PIXELS = 16,
    parameter  int NUM_CAND   = 3,
    localparam int SAD_W      = PIX_W + clog2(BLK_PIXELS),
    localparam int IDX_W      = (clog2(NUM_CAND) > 1) ? clog2(NUM_CAND) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    input  logic                   cand_first,
    input  logic                   crt_keep,
    input  logic [LANES*PIX_W-1:0] crt_pix_i,
    input  logic [LANES*PIX_W-1:0] pre_pix_i,
    output logic [LANES*PIX_W-1:0] crt_pix_o,
    output logic [LANES*PIX_W-1:0] pre_pix_o,
    output logic [SAD_W-1:0]       sad_o,
    output logic                   sad_vld,
    output logic [SAD_W-1:0]       best_sad_o,
    output logic [IDX_W-1:0]       best_idx_o,
    output logic                   best_vld
);

    localparam int BEATS  = BLK_PIXELS / LANES;
    localparam int BEAT_W = (clog2(BEATS) > 1) ? clog2(BEATS) : 1;
    localparam int TS_W   = PIX_W + clog2(LANES);

    // Stage 1: lane registers plus valid/first tags.
    logic             v1_q, f1_q;
    logic [PIX_W-1:0] ad [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        pe_ad_lane #(.PIX_W(PIX_W)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .ld_i   (in_vld),
            .keep_i (crt_keep),
            .crt_i  (crt_pix_i[k*PIX_W +: PIX_W]),
            .pre_i  (pre_pix_i[k*PIX_W +: PIX_W]),
            .crt_o  (crt_pix_o[k*PIX_W +: PIX_W]),
            .pre_o  (pre_pix_o[k*PIX_W +: PIX_W]),
            .ad_o   (ad[k])
        );
    end

    // Stage-1 tags follow the lane registers; a bubble clears the valid tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            f1_q <= 1'b0;
        end else begin
            v1_q <= in_vld;
            f1_q <= in_vld & cand_first;
        end
    end

    // Stage 2: lane sum (pass-through when LANES=1).
    logic [TS_W-1:0] tsum_d, tsum_q;
    logic            v2_q, f2_q;

    // Sum of all lane absolute differences.
    // NOTE: combinational blocks assign a default before any conditional
    // logic so no path leaves a variable unassigned (no latch inferred).
    always_comb begin
        tsum_d = '0;
        for (int k = 0; k < LANES; k++) begin
            tsum_d = tsum_d + TS_W'(ad[k]);
        end
    end

    // Stage-2 register: lane sum captured only for valid beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tsum_q <= '0;
            v2_q   <= 1'b0;
            f2_q   <= 1'b0;
        end else begin
            v2_q <= v1_q;
            f2_q <= f1_q;
            if (v1_q) begin
                tsum_q <= tsum_d;
            end
        end
    end

    // Stage 3: block accumulator and beat counter.
    logic [SAD_W-1:0]  acc_d, acc_q;
    logic [BEAT_W-1:0] beat_d, beat_q, beat_cur;
    logic              blk_start, blk_last;
    logic              blk_first_d, blk_first_q;
    logic              done_q, done_first_q;

    // A flagged beat restarts the block, silently dropping any partial sum.
    always_comb begin
        blk_start   = (beat_q == '0) || f2_q;
        beat_cur    = blk_start ? '0 : beat_q;
        blk_last    = (beat_cur == BEAT_W'(BEATS - 1));
        acc_d       = blk_start ? SAD_W'(tsum_q) : (acc_q + SAD_W'(tsum_q));
        blk_first_d = blk_start ? f2_q : blk_first_q;
        beat_d      = blk_last ? '0 : (beat_cur + 1'b1);
    end

    // Accumulate valid beats; done_q marks a finished block for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            beat_q       <= '0;
            blk_first_q  <= 1'b0;
            done_q       <= 1'b0;
            done_first_q <= 1'b0;
        end else begin
            done_q <= v2_q & blk_last;
            if (v2_q) begin
                acc_q        <= acc_d;
                beat_q       <= beat_d;
                blk_first_q  <= blk_first_d;
                done_first_q <= blk_first_d;
            end
        end
    end

    // Output stage: publish the SAD and track the window minimum.
    logic [SAD_W-1:0] sad_q, best_sad_q;
    logic [IDX_W-1:0] best_idx_q, cand_idx_q, eff_idx;
    logic             sad_vld_q, best_vld_q;
    logic             take_best, last_cand;

    // A block that began a window is candidate 0 whatever the counter says.
    always_comb begin
        eff_idx   = done_first_q ? '0 : cand_idx_q;
        take_best = (eff_idx == '0) || (acc_q < best_sad_q);
        last_cand = (eff_idx == IDX_W'(NUM_CAND - 1));
    end

    // Register the completed SAD; ties keep the earlier candidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sad_q      <= '0;
            sad_vld_q  <= 1'b0;
            best_sad_q <= '0;
            best_idx_q <= '0;
            best_vld_q <= 1'b0;
            cand_idx_q <= '0;
        end else begin
            sad_vld_q  <= done_q;
            best_vld_q <= done_q & last_cand;
            if (done_q) begin
                sad_q      <= acc_q;
                cand_idx_q <= last_cand ? '0 : IDX_W'(eff_idx + 1'b1);
                if (take_best) begin
                    best_sad_q <= acc_q;
                    best_idx_q <= eff_idx;
                end
            end
        end
    end

    assign sad_o      = sad_q;
    assign sad_vld    = sad_vld_q;
    assign best_sad_o = best_sad_q;
    assign best_idx_o = best_idx_q;
    assign best_vld   = best_vld_q;

endmodule

// File: tb/tb_pe_sad_acc.sv
// Directed testbench for pe_sad_acc with default parameters.
module tb_pe_sad_acc;
    import me_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld, cand_first, crt_keep;
    logic [31:0] crt_pix_i, pre_pix_i;
    logic [31:0] crt_pix_o, pre_pix_o;
    sad_t        sad_o, best_sad_o;
    logic [1:0]  best_idx_o;
    logic        sad_vld, best_vld;

    pe_sad_acc dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .cand_first (cand_first),
        .crt_keep   (crt_keep),
        .crt_pix_i  (crt_pix_i),
        .pre_pix_i  (pre_pix_i),
        .crt_pix_o  (crt_pix_o),
        .pre_pix_o  (pre_pix_o),
        .sad_o      (sad_o),
        .sad_vld    (sad_vld),
        .best_sad_o (best_sad_o),
        .best_idx_o (best_idx_o),
        .best_vld   (best_vld)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int sad;
        int bsad;
        int bidx;
        int bvld;
    } ev_t;
    ev_t evq[$];

    // Record every sad_vld pulse, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && sad_vld) begin
            evq.push_back('{cyc, int'(sad_o), int'(best_sad_o), int'(best_idx_o), int'(best_vld)});
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int last_edge = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rep4(input pix_t v);
        return {v, v, v, v};
    endfunction

    function automatic logic [31:0] lanes(input pix_t l0, input pix_t l1, input pix_t l2, input pix_t l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic send_beat(input logic first, input logic keep,
                             input logic [31:0] crt, input logic [31:0] pre);
        @(negedge clk);
        in_vld     = 1'b1;
        cand_first = first;
        crt_keep   = keep;
        crt_pix_i  = crt;
        pre_pix_i  = pre;
        last_edge  = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_vld     = 1'b0;
            cand_first = 1'b0;
            crt_keep   = 1'b0;
        end
    endtask

    // Pop the oldest recorded SAD event and compare all its fields.
    task automatic expect_ev(input string tag, input int sad, input int bsad,
                             input int bidx, input int bvld, input int exp_cyc);
        ev_t e;
        if (evq.size() == 0) begin
            check({tag, "_present"}, 0, 1);
        end else begin
            e = evq.pop_front();
            check({tag, "_sad"}, e.sad, sad);
            check({tag, "_best_sad"}, e.bsad, bsad);
            check({tag, "_best_idx"}, e.bidx, bidx);
            check({tag, "_best_vld"}, e.bvld, bvld);
            if (exp_cyc >= 0) check({tag, "_latency"}, e.cyc, exp_cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        rst = 1'b1; in_vld = 1'b0; cand_first = 1'b0; crt_keep = 1'b0;
        crt_pix_i = '0; pre_pix_i = '0;
        repeat (3) @(negedge clk);
        check("rst_sad", sad_o, 0);
        check("rst_sad_vld", sad_vld, 0);
        check("rst_best_sad", best_sad_o, 0);
        check("rst_best_idx", best_idx_o, 0);
        check("rst_best_vld", best_vld, 0);
        check("rst_crt_o", crt_pix_o, 0);
        check("rst_pre_o", pre_pix_o, 0);
        rst = 1'b0;

        // T1: 150 per pixel, 16 pixels -> 2400, sad_vld 3 edges after last beat.
        send_beat(1, 0, rep4(200), rep4(50));
        repeat (3) send_beat(0, 0, rep4(200), rep4(50));
        idle(1);
        check("t1_crt_echo", crt_pix_o, rep4(200));
        check("t1_pre_echo", pre_pix_o, rep4(50));
        idle(6);
        expect_ev("t1", 2400, 2400, 0, 0, last_edge + 3);

        // T2: full-scale difference in both directions -> 4080, tie keeps idx 0.
        send_beat(1, 0, rep4(255), rep4(0));
        repeat (3) send_beat(0, 0, rep4(255), rep4(0));
        t0 = last_edge;
        repeat (4) send_beat(0, 0, rep4(0), rep4(255));
        idle(7);
        expect_ev("t2a", 4080, 4080, 0, 0, t0 + 3);
        expect_ev("t2b", 4080, 4080, 0, 0, last_edge + 3);

        // T3: current pixels held at 100 after beat 1 -> 40 per beat -> 160.
        send_beat(1, 0, rep4(100), lanes(90, 110, 100, 120));
        repeat (3) send_beat(0, 1, rep4(7), lanes(90, 110, 100, 120));
        idle(1);
        check("t3_crt_held", crt_pix_o, rep4(100));
        check("t3_pre_echo", pre_pix_o, lanes(90, 110, 100, 120));
        idle(6);
        expect_ev("t3", 160, 160, 0, 0, last_edge + 3);

        // T4: window 100, 40, 40 -> best 40 at idx 1, best_vld on the third.
        send_beat(1, 0, lanes(100, 0, 0, 0), rep4(0));
        repeat (3) send_beat(0, 0, rep4(0), rep4(0));
        send_beat(0, 0, lanes(40, 0, 0, 0), rep4(0));
        repeat (3) send_beat(0, 0, rep4(0), rep4(0));
        send_beat(0, 0, lanes(0, 0, 0, 0), lanes(0, 0, 40, 0));
        repeat (3) send_beat(0, 0, rep4(0), rep4(0));
        idle(8);
        expect_ev("t4a", 100, 100, 0, 0, -1);
        expect_ev("t4b", 40, 40, 1, 0, -1);
        expect_ev("t4c", 40, 40, 1, 1, last_edge + 3);
        check("t4_hold_best_sad", best_sad_o, 40);
        check("t4_hold_best_idx", best_idx_o, 1);
        send_beat(1, 0, rep4(125), rep4(0));
        repeat (3) send_beat(0, 0, rep4(0), rep4(0));
        idle(6);
        expect_ev("t4d", 500, 500, 0, 0, last_edge + 3);

        // T5: bubbles of 1, 2, 3 cycles between beats -> same SAD, delayed pulse.
        send_beat(1, 0, rep4(200), rep4(50));
        t0 = last_edge;
        idle(1);
        send_beat(0, 0, rep4(200), rep4(50));
        idle(2);
        send_beat(0, 0, rep4(200), rep4(50));
        idle(3);
        send_beat(0, 0, rep4(200), rep4(50));
        idle(6);
        expect_ev("t5", 2400, 2400, 0, 0, t0 + 3 + 3 + 6);

        // T6a: reset after two beats discards the partial block.
        send_beat(1, 0, rep4(200), rep4(50));
        send_beat(0, 0, rep4(200), rep4(50));
        @(negedge clk);
        rst = 1'b1; in_vld = 1'b0;
        @(negedge clk);
        check("t6_rst_sad", sad_o, 0);
        check("t6_rst_best_sad", best_sad_o, 0);
        check("t6_rst_crt_o", crt_pix_o, 0);
        rst = 1'b0;
        idle(8);
        check("t6_no_sad_vld", evq.size(), 0);

        // T6b: cand_first on beat 3 restarts the block there: 4 x 10 -> 40.
        send_beat(1, 0, rep4(200), rep4(50));
        send_beat(0, 0, rep4(200), rep4(50));
        send_beat(1, 0, lanes(10, 0, 0, 0), rep4(0));
        repeat (3) send_beat(0, 0, lanes(10, 0, 0, 0), rep4(0));
        idle(8);
        check("t6_event_count", evq.size(), 1);
        expect_ev("t6b", 40, 40, 0, 0, last_edge + 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
